// File: rtl/mat_row_server.sv
// -----------------------------------------------------------------------------
// mat_row_server
//   Synthesizable SIZE x SIZE complex matrix row store serving the row-read,
//   row-write and column-write ports of the lu / triang_matrix_inv engines.
//   Row r is a packed vector; element j sits at [j*2*WIDTH +: 2*WIDTH] as
//   {imag, real}. A SIZE-cycle CLEAR sequence reinitialises the matrix.
//
//   Optional feature (macro MAT_ROW_SERVER_IDENT_EN): reset contents and the
//   clear pattern become the identity matrix (real part 1.0 on the diagonal).
//   Only legal with WIDTH=64.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              abort CLEAR, drop pending read response and requests
//   rd_addr_i/_valid_i   row read request (accepted when in_ready_o)
//   rd_row_o/rd_addr_o   read data / echoed address, 1-cycle latency
//   rd_valid_o           read data valid
//   wr_row_i/_addr_i/_valid_i   full row write
//   col_i/col_addr_i/col_valid_i  column write, element r of col_i -> row r
//   clear_i              start CLEAR sequence (ignored while clearing)
//   in_ready_o           high in IDLE; requests are only taken then
//   busy_o               high during CLEAR
// -----------------------------------------------------------------------------

// One matrix row: owns its storage and computes its post-write next value,
// which also feeds the write-first read bypass in the top level.
module mat_row_lane #(
   parameter int SIZE  = 4,
   parameter int WIDTH = 64,
   parameter int ROW   = 0
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clr_en_i,
   input  logic                        wr_en_i,
   input  logic [SIZE*2*WIDTH-1:0]     wr_row_i,
   input  logic                        col_en_i,
   input  logic [$clog2(SIZE)-1:0]     col_addr_i,
   input  logic [2*WIDTH-1:0]          col_elem_i,
   output logic [SIZE*2*WIDTH-1:0]     row_d_o
);
   localparam int EW = 2 * WIDTH;
   localparam int RW = SIZE * EW;

   function automatic logic [RW-1:0] gen_pattern();
      logic [RW-1:0] p;
      p = '0;
`ifdef MAT_ROW_SERVER_IDENT_EN
      p[ROW*EW +: WIDTH] = WIDTH'(64'h3FF0000000000000);
`endif
      return p;
   endfunction

   localparam logic [RW-1:0] PATTERN = gen_pattern();

   logic [RW-1:0] row_q;
   logic [RW-1:0] row_d;

   // Row write lands first, then the column write overrides its element.
   always_comb begin
      row_d = row_q;
      if (clr_en_i) row_d = PATTERN;
      if (wr_en_i)  row_d = wr_row_i;
      if (col_en_i) row_d[int'(col_addr_i)*EW +: EW] = col_elem_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) row_q <= PATTERN;
      else         row_q <= row_d;
   end

   assign row_d_o = row_d;
endmodule

module mat_row_server #(
   parameter int SIZE  = 4,
   parameter int WIDTH = 64
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        flush_i,
   input  logic [$clog2(SIZE)-1:0]     rd_addr_i,
   input  logic                        rd_addr_valid_i,
   output logic [SIZE*2*WIDTH-1:0]     rd_row_o,
   output logic [$clog2(SIZE)-1:0]     rd_addr_o,
   output logic                        rd_valid_o,
   input  logic [SIZE*2*WIDTH-1:0]     wr_row_i,
   input  logic [$clog2(SIZE)-1:0]     wr_addr_i,
   input  logic                        wr_valid_i,
   input  logic [SIZE*2*WIDTH-1:0]     col_i,
   input  logic [$clog2(SIZE)-1:0]     col_addr_i,
   input  logic                        col_valid_i,
   input  logic                        clear_i,
   output logic                        in_ready_o,
   output logic                        busy_o
);
   localparam int AW = $clog2(SIZE);
   localparam int EW = 2 * WIDTH;
   localparam int RW = SIZE * EW;

`ifdef MAT_ROW_SERVER_IDENT_EN
   generate
      if (WIDTH != 64) begin : g_width_err
         $error("mat_row_server: identity pattern requires WIDTH=64");
      end
   endgenerate
`endif

   typedef enum logic {IDLE, CLEAR} state_e;

   state_e          state_q;
   logic [AW-1:0]   cnt_q;
   logic            busy_q;
   logic            ready_q;
   logic            rd_valid_q;
   logic [RW-1:0]   rd_row_q;
   logic [AW-1:0]   rd_addr_q;

   logic            acc_en;
   logic [SIZE-1:0][RW-1:0] row_nxt;

   // Requests are taken only in IDLE and never in a flush cycle.
   assign acc_en = ready_q & ~flush_i;

   // The clear write of the current row still happens in a flush cycle, so
   // every row the counter has reached is cleared when CLEAR is aborted.
   generate
      for (genvar r = 0; r < SIZE; r++) begin : g_lane
         mat_row_lane #(.SIZE(SIZE), .WIDTH(WIDTH), .ROW(r)) u_lane (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clr_en_i   ((state_q == CLEAR) && (cnt_q == AW'(r))),
            .wr_en_i    (acc_en & wr_valid_i & (wr_addr_i == AW'(r))),
            .wr_row_i   (wr_row_i),
            .col_en_i   (acc_en & col_valid_i),
            .col_addr_i (col_addr_i),
            .col_elem_i (col_i[r*EW +: EW]),
            .row_d_o    (row_nxt[r])
         );
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
         rd_valid_q <= 1'b0;
         rd_row_q   <= '0;
         rd_addr_q  <= '0;
      end else if (flush_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
         rd_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               rd_valid_q <= rd_addr_valid_i;
               if (rd_addr_valid_i) begin
                  // Write-first: bypass the post-write row value.
                  rd_row_q  <= row_nxt[rd_addr_i];
                  rd_addr_q <= rd_addr_i;
               end
               if (clear_i) begin
                  state_q <= CLEAR;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
               end
            end
            CLEAR: begin
               rd_valid_q <= 1'b0;
               cnt_q      <= cnt_q + 1'b1;
               if (cnt_q == AW'(SIZE - 1)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign rd_row_o   = rd_row_q;
   assign rd_addr_o  = rd_addr_q;
   assign rd_valid_o = rd_valid_q;
   assign in_ready_o = ready_q;
   assign busy_o     = busy_q;
endmodule

// File: tb/tb_mat_row_server.sv
module tb_mat_row_server;
   localparam int SIZE  = 4;
   localparam int WIDTH = 64;
   localparam int AW    = 2;
   localparam int EW    = 2 * WIDTH;
   localparam int RW    = SIZE * EW;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic [AW-1:0] rd_addr;
   logic          rd_addr_valid;
   logic [RW-1:0] rd_row;
   logic [AW-1:0] rd_addr_echo;
   logic          rd_valid;
   logic [RW-1:0] wr_row;
   logic [AW-1:0] wr_addr;
   logic          wr_valid;
   logic [RW-1:0] col;
   logic [AW-1:0] col_addr;
   logic          col_valid;
   logic          clear;
   logic          in_ready;
   logic          busy;

   mat_row_server #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .rd_addr_i(rd_addr), .rd_addr_valid_i(rd_addr_valid),
      .rd_row_o(rd_row), .rd_addr_o(rd_addr_echo), .rd_valid_o(rd_valid),
      .wr_row_i(wr_row), .wr_addr_i(wr_addr), .wr_valid_i(wr_valid),
      .col_i(col), .col_addr_i(col_addr), .col_valid_i(col_valid),
      .clear_i(clear), .in_ready_o(in_ready), .busy_o(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vectors = 0;
   int miscompares = 0;

   // Reference model: matrix of {imag, real} elements.
   logic [EW-1:0] mem [SIZE][SIZE];

   function automatic logic [EW-1:0] pat(int r, int j);
`ifdef MAT_ROW_SERVER_IDENT_EN
      if (r == j) return {64'h0, 64'h3FF0000000000000};
`endif
      return '0;
   endfunction

   function automatic logic [RW-1:0] mrow(int r);
      logic [RW-1:0] v;
      for (int j = 0; j < SIZE; j++) v[j*EW +: EW] = mem[r][j];
      return v;
   endfunction

   function automatic logic [RW-1:0] rnd_row();
      logic [RW-1:0] v;
      for (int i = 0; i < RW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [EW-1:0] cplx(real re, real im);
      return {$realtobits(im), $realtobits(re)};
   endfunction

   task automatic m_clear_row(int r);
      for (int j = 0; j < SIZE; j++) mem[r][j] = pat(r, j);
   endtask

   task automatic m_write(int a, logic [RW-1:0] d);
      for (int j = 0; j < SIZE; j++) mem[a][j] = d[j*EW +: EW];
   endtask

   task automatic m_col(int c, logic [RW-1:0] d);
      for (int r = 0; r < SIZE; r++) mem[r][c] = d[r*EW +: EW];
   endtask

   task automatic chk(string tag, logic [RW-1:0] obs, logic [RW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkb(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; rd_addr_valid = 0; wr_valid = 0; col_valid = 0; clear = 0;
   endtask

   task automatic read_chk(int a, string tag);
      rd_addr = AW'(a); rd_addr_valid = 1;
      tick();
      rd_addr_valid = 0;
      chkb({tag, "_vld"}, 32'(rd_valid), 1);
      chkb({tag, "_addr"}, 32'(rd_addr_echo), a);
      chk({tag, "_row"}, rd_row, mrow(a));
   endtask

   logic [RW-1:0] d, cd, w_held, exp_row;
   int exp_addr;

   initial begin
      rst_n = 0; rd_addr = '0; wr_row = '0; wr_addr = '0; col = '0; col_addr = '0;
      idle_inputs();
      for (int r = 0; r < SIZE; r++) m_clear_row(r);

      // Reset state
      tick(); tick();
      chkb("rst_vld", 32'(rd_valid), 0);
      chkb("rst_addr", 32'(rd_addr_echo), 0);
      chk("rst_row", rd_row, '0);
      chkb("rst_busy", 32'(busy), 0);
      chkb("rst_ready", 32'(in_ready), 1);
      rst_n = 1;
      tick();

      // Read row 2 after reset, then response holds with valid low
      read_chk(2, "rd2");
      tick();
      chkb("rd2_drop", 32'(rd_valid), 0);
      chk("rd2_hold", rd_row, mrow(2));

      // Row write with known doubles, read back next cycle
      for (int j = 0; j < SIZE; j++) d[j*EW +: EW] = cplx(j + 1.0, j + 10.0);
      wr_row = d; wr_addr = 1; wr_valid = 1;
      tick();
      wr_valid = 0;
      m_write(1, d);
      read_chk(1, "wr_rd1");

      // Same-cycle row write, column write and read of the same row
      for (int j = 0; j < SIZE; j++) d[j*EW +: EW] = cplx(5.0, 5.0);
      for (int r = 0; r < SIZE; r++) cd[r*EW +: EW] = cplx(r + 20.0, 0.0);
      wr_row = d; wr_addr = 3; wr_valid = 1;
      col = cd; col_addr = 0; col_valid = 1;
      m_write(3, d);
      m_col(0, cd);
      read_chk(3, "coll");
      wr_valid = 0; col_valid = 0;
      chkb("coll_e0", 32'(rd_row[63:0] == $realtobits(23.0)), 1);
      chkb("coll_e1", 32'(rd_row[EW +: 64] == $realtobits(5.0)), 1);

      // Back-to-back reads
      for (int i = 0; i < SIZE; i++) begin
         rd_addr = AW'(i); rd_addr_valid = 1;
         tick();
         chkb("b2b_vld", 32'(rd_valid), 1);
         chkb("b2b_addr", 32'(rd_addr_echo), i);
         chk("b2b_row", rd_row, mrow(i));
      end
      rd_addr_valid = 0;
      tick();
      exp_row = mrow(SIZE - 1); exp_addr = SIZE - 1;

      // Randomized mixed traffic
      for (int i = 0; i < 24; i++) begin
         wr_valid = 1'($urandom_range(0, 1));
         col_valid = 1'($urandom_range(0, 1));
         rd_addr_valid = 1'($urandom_range(0, 1));
         wr_addr = AW'($urandom_range(0, SIZE - 1));
         col_addr = AW'($urandom_range(0, SIZE - 1));
         rd_addr = AW'($urandom_range(0, SIZE - 1));
         wr_row = rnd_row(); col = rnd_row();
         if (wr_valid) m_write(int'(wr_addr), wr_row);
         if (col_valid) m_col(int'(col_addr), col);
         if (rd_addr_valid) begin
            exp_row = mrow(int'(rd_addr)); exp_addr = int'(rd_addr);
         end
         tick();
         chkb("rnd_vld", 32'(rd_valid), 32'(rd_addr_valid));
         chkb("rnd_addr", 32'(rd_addr_echo), exp_addr);
         chk("rnd_row", rd_row, exp_row);
      end
      idle_inputs();
      tick();

      // CLEAR with a read and a write held throughout
      clear = 1;
      tick();
      clear = 0;
      w_held = rnd_row();
      wr_row = w_held; wr_addr = 0; wr_valid = 1;
      rd_addr = 1; rd_addr_valid = 1;
      for (int k = 0; k < SIZE; k++) begin
         chkb("clr_busy", 32'(busy), 1);
         chkb("clr_ready", 32'(in_ready), 0);
         chkb("clr_vld", 32'(rd_valid), 0);
         tick();
      end
      chkb("clr_done_busy", 32'(busy), 0);
      chkb("clr_done_ready", 32'(in_ready), 1);
      chkb("clr_done_vld", 32'(rd_valid), 0);
      for (int r = 0; r < SIZE; r++) m_clear_row(r);
      m_write(0, w_held);
      tick();  // held read/write accepted here
      idle_inputs();
      chkb("held_vld", 32'(rd_valid), 1);
      chk("held_rd1", rd_row, mrow(1));
      for (int r = 0; r < SIZE; r++) read_chk(r, "post_clr");

      // Fill, start CLEAR, flush in the second CLEAR cycle
      for (int r = 0; r < SIZE; r++) begin
         d = rnd_row();
         wr_row = d; wr_addr = AW'(r); wr_valid = 1;
         m_write(r, d);
         tick();
      end
      idle_inputs();
      clear = 1;
      tick();
      clear = 0;
      tick();
      flush = 1; clear = 1;
      rd_addr = 3; rd_addr_valid = 1;
      wr_row = rnd_row(); wr_addr = 2; wr_valid = 1;
      tick();
      idle_inputs();
      m_clear_row(0); m_clear_row(1);
      chkb("fl_busy", 32'(busy), 0);
      chkb("fl_ready", 32'(in_ready), 1);
      chkb("fl_vld", 32'(rd_valid), 0);
      for (int r = 0; r < SIZE; r++) read_chk(r, "post_fl");

      // Flush with clear and a read in IDLE: no CLEAR, no response
      flush = 1; clear = 1; rd_addr = 0; rd_addr_valid = 1;
      tick();
      idle_inputs();
      chkb("flc_busy", 32'(busy), 0);
      chkb("flc_ready", 32'(in_ready), 1);
      chkb("flc_vld", 32'(rd_valid), 0);
      tick();
      chkb("flc_busy2", 32'(busy), 0);
      read_chk(3, "flc_rd3");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mat_row_server.md
Name: mat_row_server

Overview:
- Synthesizable matrix row store that answers the row-read / row-write / column-write interface driven by the lu and triang_matrix_inv engines. It replaces the behavioural memory loop on the bench side.
- Holds one SIZE x SIZE complex matrix as SIZE rows. Row r is a packed vector of SIZE elements; element j sits at bits [j*2*WIDTH +: 2*WIDTH] as {imag, real}, with real in the low half.
- Provides a multi-cycle CLEAR sequence so a matrix can be reinitialised between LU and inversion passes.

Parameters:
- SIZE, 4, matrix dimension (rows and elements per row); power of two, at least 2.
- WIDTH, 64, bits per real or imaginary part (IEEE double).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  abort CLEAR and drop any pending read response
- rd_addr_i  in  $clog2(SIZE)  row read address (engine mat_row_addr_o)
- rd_addr_valid_i  in  1  read request
- rd_row_o  out  SIZE*2*WIDTH  row read data (engine mat_row_i)
- rd_addr_o  out  $clog2(SIZE)  echoed read address (engine mat_row_addr_i)
- rd_valid_o  out  1  read data valid (engine mat_row_valid_i)
- wr_row_i  in  SIZE*2*WIDTH  full row write data
- wr_addr_i  in  $clog2(SIZE)  row write address
- wr_valid_i  in  1  row write request
- col_i  in  SIZE*2*WIDTH  column write data; element r goes to row r
- col_addr_i  in  $clog2(SIZE)  column index written in every row
- col_valid_i  in  1  column write request
- clear_i  in  1  start CLEAR sequence
- in_ready_o  out  1  write ports and read port accepted
- busy_o  out  1  CLEAR in progress

Behaviour:
- Reset (async, rst_ni=0):
  - All storage is 0.
  - rd_row_o=0, rd_addr_o=0, rd_valid_o=0, busy_o=0.
  - State IDLE, so in_ready_o=1.
- States: IDLE and CLEAR. in_ready_o is high exactly when state is IDLE. busy_o is high exactly when state is CLEAR.
- IDLE to CLEAR: clear_i=1 while in IDLE. The clear counter loads 0.
- CLEAR: writes row cnt with the clear pattern each cycle, cnt counting 0 to SIZE-1.
  - After the cycle that writes row SIZE-1, the state returns to IDLE. CLEAR lasts exactly SIZE cycles.
  - clear_i while already in CLEAR is ignored.
- Read, accepted when rd_addr_valid_i and in_ready_o are both high:
  - Latency is exactly 1 cycle.
  - Next cycle: rd_row_o = row[rd_addr_i], rd_addr_o = rd_addr_i, rd_valid_o=1.
  - Otherwise rd_valid_o=0 next cycle, and rd_row_o and rd_addr_o hold their values.
- Back-to-back reads give one response per cycle. There is no backpressure on the read path.
- Row write: when wr_valid_i and in_ready_o are high, row[wr_addr_i] updates at the clock edge.
- Column write: when col_valid_i and in_ready_o are high, element col_addr_i of every row r takes col_i element r.
- Same-cycle row and column write: the row write applies first, then the column write overrides the element at (wr_addr_i, col_addr_i). All other elements of that row come from wr_row_i.
- Read/write collision in the same cycle:
  - Reads are write-first. rd_row_o returns the post-write contents of the addressed row, including column-write overrides.
  - Implement with a bypass mux, not a second cycle.
- During CLEAR, all requests arriving on the read and write ports are dropped. Initiators hold their requests until in_ready_o=1. rd_valid_o is 0 throughout CLEAR.
- flush_i (highest priority after reset):
  - Next cycle: state is IDLE and rd_valid_o=0.
  - Rows already cleared stay cleared; rows not yet reached keep their old data.
  - Reads and writes presented in the flush cycle are dropped.
  - flush_i together with clear_i in IDLE: flush wins and CLEAR does not start.
- Clear pattern: every element 0 (real=0, imag=0).
- Address values are always in range since SIZE is a power of two. No wrap handling is needed beyond the counter returning to 0.

Optional Feature:
- Macro: MAT_ROW_SERVER_IDENT_EN
- Defined:
  - The clear pattern and reset contents become the identity matrix.
  - For row r, element r has real=64'h3FF0000000000000 (1.0) and imag=0. All other elements are 0.
  - Used to seed triangular-inverse runs.
  - Valid only for WIDTH=64; elaboration error otherwise.
- Undefined: the clear pattern and reset contents are all zeros, as described above.

Test Plan:
- Reset, then read row 2 -> rd_valid_o=1 one cycle later, rd_addr_o=2, rd_row_o=0 (identity row 2 with the macro: real of element 2 = 64'h3FF0000000000000).
- Row write to row 1 with element j = {imag=j+10.0, real=j+1.0}, then read row 1 next cycle -> exact data returned, latency 1.
- Same cycle: row write to row 3 = all 5.0, column write col_addr_i=0 with element r = r+20.0, read row 3 -> element 0 real=23.0, elements 1..3 real=5.0 in the same-cycle response.
- Reads to rows 0,1,2,3 on four consecutive cycles -> four consecutive rd_valid_o pulses with addresses 0,1,2,3 in order.
- clear_i pulse, with a read and a write held throughout -> busy_o=1 and in_ready_o=0 for exactly 4 cycles, all rows zero afterwards, held write accepted on the first IDLE cycle.
- clear_i, then flush_i in the 2nd CLEAR cycle -> IDLE next cycle, rows 0-1 cleared, rows 2-3 unchanged, rd_valid_o=0.
